instr_fetch_queue: RTL and testbench
====================================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameters: DPW, rv32i_pkg default, datapath/address width; DEPTH, default 2, instruction queue entries (credit limit).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; asynchronous and active-high.
REQ-004 PCF  in  DPW  current fetch PC from the PC register.
REQ-005 pc_adv  out  1  request accepted this cycle; hazard logic stalls the PC register (stallF) while pc_adv=0.
REQ-006 imem_req_valid / imem_req_ready / imem_req_addr  out / in / out  1/1/DPW  instruction-memory request handshake.
REQ-007 imem_rsp_valid / imem_rsp_data  in / in  1/32  in-order response; no backpressure.
REQ-008 stallD  in  1  decode holds the current instruction.
REQ-009 flushD  in  1  kill all queued and in-flight instructions.
REQ-010 validD, InstrD, PCD, PCPlus4D  out  1/32/DPW/DPW  decode-stage instruction bundle.

Function
REQ-011 imem_req_valid = !rst_state && !flushD && (outstanding + count < DEPTH); imem_req_addr = PCF.
REQ-012 pc_adv = imem_req_valid && imem_req_ready; each accepted request pushes PCF into an in-order PC tag queue.
REQ-013 Response with drop_cnt=0: push {imem_rsp_data, PC tag, PC tag+4} into queue; PCPlus4D wraps modulo 2^DPW.
REQ-014 Response with drop_cnt>0: discard, decrement drop_cnt, pop PC tag; queue unchanged.
REQ-015 outstanding increments on pc_adv, decrements on every response; both same cycle -> unchanged; never exceeds DEPTH.
REQ-016 Queue outputs are registered from head: validD=(count>0); InstrD/PCD/PCPlus4D = head entry; response pushed at cycle M visible at M+1 (min fetch-to-decode latency: request N, response N+1, validD N+2).
REQ-017 Pop when validD && !stallD && !flushD; push+pop same cycle keeps count; push into full queue impossible by credit rule.
REQ-018 validD=0 -> InstrD=32'h00000013 (NOP), PCD/PCPlus4D hold last value.
REQ-019 flushD: count<=0, drop_cnt<=outstanding-(response this cycle ?1:0)+drop_cnt adjustment so every pre-flush in-flight response is discarded; no request issued that cycle; a response arriving in the flush cycle is discarded.
REQ-020 flushD and stallD together: flush wins.
REQ-021 imem_rsp_valid with outstanding=0 and drop_cnt=0 is a protocol error: ignored, sticky assertion fires in simulation.

Reset
REQ-022 rst asserted (any time, mid-transfer included): count=0, outstanding=0, drop_cnt=0, validD=0, InstrD=NOP, PCD=0, PCPlus4D=0, imem_req_valid=0, pc_adv=0.
REQ-023 First request issued the first cycle after rst deasserts; responses to pre-reset requests are the memory's responsibility (memory shares rst).

Structure
REQ-024 rv32i_pkg holds DPW, INSTR_NOP=32'h00000013 and the fetch bundle struct {instr, pc, pc_plus4}.
REQ-025 One sub-module, fetch_fifo: parameterised DEPTH-entry synchronous FIFO of the bundle struct with count, full, empty; instantiated for instruction queue; PC tag queue may reuse it.

Verification
REQ-026 Reset release, ready=1, 1-cycle memory, PCF=0x0 then 0x4 -> validD at cycle 3 with PCD=0x0, InstrD=rsp data, PCPlus4D=0x4; then 0x4 next cycle.
REQ-027 stallD held 5 cycles with ready=1 -> exactly DEPTH=2 requests outstanding/queued, pc_adv=0 afterward, InstrD/PCD stable, no drop.
REQ-028 flushD with 2 requests outstanding -> validD=0 next cycle; next 2 responses discarded; first post-flush response (PCF=0x100) appears with PCD=0x100.
REQ-029 Response and flushD same cycle -> response dropped, drop_cnt correct, subsequent instruction from new PC.
REQ-030 PCF=0xFFFFFFFC -> PCPlus4D=0x00000000.
REQ-031 rst asserted with 2 outstanding and 1 queued -> all outputs reset values asynchronously, before next clk edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions: datapath width, canonical NOP encoding and
// the decode-stage fetch bundle.
package rv32i_pkg;

    localparam int          DPW       = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]    instr;
        logic [DPW-1:0] pc;
        logic [DPW-1:0] pc_plus4;
    } fetch_bundle_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus: PC input, instruction-memory request/response and the
// decode-stage bundle. master = fetch queue, slave = surrounding pipeline/memory.
interface instr_fetch_queue_if #(
    parameter int DPW = rv32i_pkg::DPW
);
    logic [DPW-1:0] PCF;
    logic           pc_adv;
    logic           imem_req_valid;
    logic           imem_req_ready;
    logic [DPW-1:0] imem_req_addr;
    logic           imem_rsp_valid;
    logic [31:0]    imem_rsp_data;
    logic           stallD;
    logic           flushD;
    logic           validD;
    logic [31:0]    InstrD;
    logic [DPW-1:0] PCD;
    logic [DPW-1:0] PCPlus4D;

    modport master (
        input  PCF, imem_req_ready, imem_rsp_valid, imem_rsp_data, stallD, flushD,
        output pc_adv, imem_req_valid, imem_req_addr, validD, InstrD, PCD, PCPlus4D
    );

    modport slave (
        output PCF, imem_req_ready, imem_rsp_valid, imem_rsp_data, stallD, flushD,
        input  pc_adv, imem_req_valid, imem_req_addr, validD, InstrD, PCD, PCPlus4D
    );

endinterface

// File: rtl/instr_fetch_queue_chk.sv
// Simulation-only invariants of the fetch queue: credit bounds, tag/outstanding
// agreement and a sticky flag for responses that arrive with nothing in flight.
module instr_fetch_queue_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic [CW-1:0] outstanding,
    input logic [CW-1:0] drop_cnt,
    input logic [CW-1:0] tag_count,
    input logic          tag_empty,
    input logic          tag_full,
    input logic          tag_push,
    input logic          tag_pop,
    input logic          q_push,
    input logic          q_pop,
    input logic          q_full,
    input logic          proto_err
);

    a_no_orphan_rsp:  assert property (@(posedge clk) disable iff (rst) !proto_err);
    a_credit_bound:   assert property (@(posedge clk) disable iff (rst) outstanding <= CW'(DEPTH));
    a_drop_bound:     assert property (@(posedge clk) disable iff (rst) drop_cnt <= outstanding);
    a_tag_tracks:     assert property (@(posedge clk) disable iff (rst) tag_count == outstanding);
    a_tag_empty:      assert property (@(posedge clk) disable iff (rst) tag_empty == (outstanding == CW'(0)));
    a_tag_no_ovf:     assert property (@(posedge clk) disable iff (rst) !(tag_push && tag_full && !tag_pop));
    a_queue_no_ovf:   assert property (@(posedge clk) disable iff (rst) !(q_push && q_full && !q_pop));

endmodule

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with occupancy count; head entry is presented
// combinationally from storage. clr empties the queue in one cycle.
module fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_bundle_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  T                           wdata,
    output T                           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
    endfunction

    // Qualify push/pop against occupancy; a full queue may still accept when popping.
    always_comb begin
        do_pop_s  = pop && (count_r != CW'(0));
        do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else if (clr) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_s && !clr) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == CW'(0));

endmodule

// File: rtl/instr_fetch_queue.sv
// Credit-based instruction fetch queue: issues imem requests while credits
// remain, tags them with their PC, and discards responses belonging to a flushed stream.
import rv32i_pkg::*;

module instr_fetch_queue #(
    parameter int DPW   = rv32i_pkg::DPW,
    parameter int DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]  outstanding_r;
    logic [CW-1:0]  drop_cnt_r;
    logic [DPW-1:0] last_pc_r;
    logic [DPW-1:0] last_pc4_r;
    logic           proto_err_r;

    logic [CW:0]    credit_use_s;
    logic           req_valid_s;
    logic           pc_adv_s;
    logic           rsp_legal_s;
    logic           rsp_keep_s;
    logic           q_pop_s;
    logic [CW-1:0]  q_count_s;
    logic           q_full_s;
    logic           q_empty_s;
    fetch_bundle_t  q_wdata_s;
    fetch_bundle_t  q_head_s;
    logic [DPW-1:0] pc_tag_s;
    logic [CW-1:0]  tag_count_s;
    logic           tag_full_s;
    logic           tag_empty_s;

    // Credits cover both in-flight requests and queued instructions, so a response can always be stored.
    always_comb begin
        credit_use_s       = {1'b0, outstanding_r} + {1'b0, q_count_s};
        req_valid_s        = !rst && !bus.flushD && (credit_use_s < (CW+1)'(DEPTH));
        pc_adv_s           = req_valid_s && bus.imem_req_ready;
        rsp_legal_s        = bus.imem_rsp_valid && (outstanding_r != CW'(0));
        rsp_keep_s         = rsp_legal_s && (drop_cnt_r == CW'(0)) && !bus.flushD;
        q_pop_s            = !q_empty_s && !bus.stallD && !bus.flushD;
        q_wdata_s.instr    = bus.imem_rsp_data;
        q_wdata_s.pc       = pc_tag_s;
        q_wdata_s.pc_plus4 = pc_tag_s + DPW'(4);
    end

    // Credit, drop and last-shown-PC bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_r <= CW'(0);
            drop_cnt_r    <= CW'(0);
            last_pc_r     <= DPW'(0);
            last_pc4_r    <= DPW'(0);
            proto_err_r   <= 1'b0;
        end else begin
            case ({pc_adv_s, rsp_legal_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            // Everything still in flight after this cycle belongs to the killed stream.
            if (bus.flushD) begin
                drop_cnt_r <= outstanding_r - (rsp_legal_s ? CW'(1) : CW'(0));
            end else if (rsp_legal_s && (drop_cnt_r != CW'(0))) begin
                drop_cnt_r <= drop_cnt_r - CW'(1);
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
            if (!q_empty_s) begin
                last_pc_r  <= q_head_s.pc;
                last_pc4_r <= q_head_s.pc_plus4;
            end
            proto_err_r <= proto_err_r || (bus.imem_rsp_valid && (outstanding_r == CW'(0))
                                           && (drop_cnt_r == CW'(0)));
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_bundle_t)
    ) u_instr_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.flushD),
        .push  (rsp_keep_s),
        .pop   (q_pop_s),
        .wdata (q_wdata_s),
        .rdata (q_head_s),
        .count (q_count_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [DPW-1:0])
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .push  (pc_adv_s),
        .pop   (rsp_legal_s),
        .wdata (bus.PCF),
        .rdata (pc_tag_s),
        .count (tag_count_s),
        .full  (tag_full_s),
        .empty (tag_empty_s)
    );

    instr_fetch_queue_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .outstanding (outstanding_r),
        .drop_cnt    (drop_cnt_r),
        .tag_count   (tag_count_s),
        .tag_empty   (tag_empty_s),
        .tag_full    (tag_full_s),
        .tag_push    (pc_adv_s),
        .tag_pop     (rsp_legal_s),
        .q_push      (rsp_keep_s),
        .q_pop       (q_pop_s),
        .q_full      (q_full_s),
        .proto_err   (proto_err_r)
    );

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = bus.PCF;
    assign bus.pc_adv         = pc_adv_s;
    assign bus.validD         = !q_empty_s;
    assign bus.InstrD         = q_empty_s ? INSTR_NOP  : q_head_s.instr;
    assign bus.PCD            = q_empty_s ? last_pc_r  : q_head_s.pc;
    assign bus.PCPlus4D       = q_empty_s ? last_pc4_r : q_head_s.pc_plus4;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue with an in-order memory model and a
// queue-level reference of the decode stream, plus directed literal scenarios.
module tb_instr_fetch_queue;
    import rv32i_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DPW(DPW), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int passes = 0;
    int cyc    = 0;
    int lat    = 1;
    int last_due = 0;

    logic [31:0] pc_reg;
    logic [31:0] m_q_pc[$];
    logic [31:0] m_q_instr[$];
    logic [31:0] m_pend[$];
    int          m_drop;
    logic [31:0] m_last_pc, m_last_pc4;
    logic [31:0] mem_addr[$];
    int          mem_due[$];

    logic        obs_valid, obs_req, obs_adv;
    logic [31:0] obs_instr, obs_pcd, obs_pc4;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    endtask

    task automatic model_clear();
        m_q_pc.delete(); m_q_instr.delete(); m_pend.delete();
        mem_addr.delete(); mem_due.delete();
        m_drop = 0; m_last_pc = 32'h0; m_last_pc4 = 32'h0;
    endtask

    // Mid-cycle asynchronous reset; outputs must change before the next clock edge.
    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_validD",   32'(bus.validD), 32'h0);
        chk("rst_InstrD",   bus.InstrD, 32'h0000_0013);
        chk("rst_PCD",      bus.PCD, 32'h0);
        chk("rst_PCPlus4D", bus.PCPlus4D, 32'h0);
        chk("rst_req",      32'(bus.imem_req_valid), 32'h0);
        chk("rst_adv",      32'(bus.pc_adv), 32'h0);
        bus.imem_rsp_valid = 1'b0; bus.stallD = 1'b0; bus.flushD = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        model_clear();
        cyc = 1; last_due = 1; pc_reg = 32'h0;
    endtask

    // One clock cycle: drive, compare against the reference, advance the reference.
    task automatic step(input bit stall, input bit flush, input logic [31:0] target, input bit ready);
        bit rsp_v, exp_req, exp_adv, exp_valid;
        logic [31:0] rsp_d, tag, tmp;
        int due, tmpi;
        rsp_v = 1'b0;
        if (mem_addr.size() > 0) rsp_v = (mem_due[0] <= cyc);
        rsp_d = rsp_v ? mem_data(mem_addr[0]) : 32'hDEAD_BEEF;
        bus.PCF = pc_reg; bus.imem_req_ready = ready; bus.stallD = stall; bus.flushD = flush;
        bus.imem_rsp_valid = rsp_v; bus.imem_rsp_data = rsp_d;
        exp_req   = !flush && ((m_pend.size() + m_q_pc.size()) < DEPTH);
        exp_adv   = exp_req && ready;
        exp_valid = (m_q_pc.size() > 0);
        @(negedge clk);
        obs_valid = bus.validD; obs_req = bus.imem_req_valid; obs_adv = bus.pc_adv;
        obs_instr = bus.InstrD; obs_pcd = bus.PCD; obs_pc4 = bus.PCPlus4D;
        chk("req_valid", 32'(obs_req), 32'(exp_req));
        chk("pc_adv",    32'(obs_adv), 32'(exp_adv));
        if (exp_req) chk("req_addr", bus.imem_req_addr, pc_reg);
        chk("validD",   32'(obs_valid), 32'(exp_valid));
        chk("InstrD",   obs_instr, exp_valid ? m_q_instr[0] : 32'h0000_0013);
        chk("PCD",      obs_pcd, exp_valid ? m_q_pc[0] : m_last_pc);
        chk("PCPlus4D", obs_pc4, exp_valid ? m_q_pc[0] + 32'd4 : m_last_pc4);
        if (exp_valid) begin m_last_pc = m_q_pc[0]; m_last_pc4 = m_q_pc[0] + 32'd4; end
        if (exp_valid && !stall && !flush) begin
            tmp = m_q_pc.pop_front(); tmp = m_q_instr.pop_front();
        end
        if (rsp_v) begin
            tag = m_pend.pop_front(); tmp = mem_addr.pop_front(); tmpi = mem_due.pop_front();
            if (flush) begin
            end else if (m_drop > 0) begin
                m_drop--;
            end else begin
                m_q_pc.push_back(tag); m_q_instr.push_back(rsp_d);
            end
        end
        if (flush) begin
            m_q_pc.delete(); m_q_instr.delete();
            m_drop = m_pend.size();
        end
        if (exp_adv) begin
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            m_pend.push_back(pc_reg); mem_addr.push_back(pc_reg); mem_due.push_back(due);
            last_due = due;
        end
        pc_reg = flush ? target : (exp_adv ? pc_reg + 32'd4 : pc_reg);
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        bus.PCF = 32'h0; bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = 32'h0; bus.stallD = 1'b0; bus.flushD = 1'b0;
        pc_reg = 32'h0;
        model_clear();
        @(posedge clk); #1;

        // Basic fetch-to-decode latency with a 1-cycle memory.
        do_reset(); lat = 1;
        step(1'b0, 1'b0, 32'h0, 1'b1); step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("lat_validD", 32'(obs_valid), 32'h1);
        chk("lat_PCD", obs_pcd, 32'h0);
        chk("lat_InstrD", obs_instr, 32'h1357_9BDF);
        chk("lat_PCPlus4D", obs_pc4, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("lat_PCD_next", obs_pcd, 32'h4);
        chk("lat_InstrD_next", obs_instr, 32'h1357_9BDB);

        // Decode stalled from the start: credits fill and the PC stops advancing.
        do_reset(); lat = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("stall_validD", 32'(obs_valid), 32'h1);
        chk("stall_PCD", obs_pcd, 32'h0);
        chk("stall_InstrD", obs_instr, 32'h1357_9BDF);
        chk("stall_adv", 32'(obs_adv), 32'h0);
        chk("stall_req", 32'(obs_req), 32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with two requests in flight; both responses are discarded.
        do_reset(); lat = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1); step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h100, 1'b1);
        chk("flush_noreq", 32'(obs_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush_validD_next", 32'(obs_valid), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("flush_new_validD", 32'(obs_valid), 32'h1);
        chk("flush_new_PCD", obs_pcd, 32'h100);
        chk("flush_new_PCPlus4D", obs_pc4, 32'h104);
        chk("flush_new_InstrD", obs_instr, 32'h1357_9ADF);

        // Response and flush in the same cycle.
        do_reset(); lat = 2;
        step(1'b0, 1'b0, 32'h0, 1'b1); step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("rspflush_validD", 32'(obs_valid), 32'h1);
        chk("rspflush_PCD", obs_pcd, 32'h200);
        chk("rspflush_InstrD", obs_instr, 32'h1357_99DF);

        // PC+4 wraps at the top of the address space.
        do_reset(); lat = 1; pc_reg = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_PCD", obs_pcd, 32'hFFFF_FFFC);
        chk("wrap_PCPlus4D", obs_pc4, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_next_PCD", obs_pcd, 32'h0);

        // Asynchronous reset with work in flight and queued.
        do_reset(); lat = 3;
        step(1'b0, 1'b0, 32'h0, 1'b1); step(1'b0, 1'b0, 32'h0, 1'b1);
        do_reset(); lat = 1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] tgt;
            if (($urandom % 300) == 0) begin
                do_reset();
                pc_reg = $urandom & 32'hFFFF_FFFC;
            end
            if (($urandom % 16) == 0) lat = $urandom_range(1, 3);
            tgt = (($urandom % 8) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step(($urandom % 4) == 0, ($urandom % 20) == 0, tgt, ($urandom % 4) != 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
